// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 prefix and arrow scan codes, receiver/decoder state encodings, decoded key event type.
package ps2_pkg;
    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;
    localparam logic [7:0] KEY_UP   = 8'h75;
    localparam logic [7:0] KEY_DOWN = 8'h72;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes PS2_CLK/PS2_DATA and receives one 11-bit frame with a watchdog; byte_vld/byte_err
// are combinational on the CLK50 edge that samples the stop bit (or on abort). No backpressure: strobes last one cycle.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int WDOG_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK50,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       byte_vld,
    output logic       byte_err,
    output logic [7:0] byte_dat
);
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev, fall, bit_dat;
    rx_state_t              state, state_nxt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit, par_ok, abort, stop_smp;
    logic [WW-1:0]          wdog;

    // Idle-high reset values so a released reset never looks like a falling edge.
    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_dat = dat_sync[SYNC_STAGES-1];
    assign abort   = (state != IDLE) && (wdog == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Abort wins over a coincident falling edge.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!bit_dat) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        par_ok   = ^{shreg, par_bit};
        stop_smp = fall && !abort && (state == STOP);
        byte_vld = stop_smp && bit_dat && par_ok;
        byte_err = abort || (stop_smp && !(bit_dat && par_ok));
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            wdog    <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
                wdog    <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
            if (fall && !abort) begin
                if (state == DATA) begin
                    shreg   <= {bit_dat, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == PARITY) par_bit <= bit_dat;
            end
        end
    end

    assign byte_dat = shreg;
endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 scan-code decoder (E0/F0 prefixes) driving an arrow-key LED level; optional PS2_TYPEMATIC_FILTER_EN.
// Events register one cycle after the stop-bit sample edge; no backpressure, key_valid/frame_err are single-cycle pulses.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int WDOG_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK50,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err,
    output logic [6:0] LED
);
    logic       byte_vld, byte_err;
    logic [7:0] byte_dat;
    dec_state_t dec_state, dec_nxt;
    key_evt_t   evt;
    logic       evt_vld, emit;

    ps2_rx_frame #(
        .WDOG_CYCLES(WDOG_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .CLK50   (CLK50),
        .RST_N   (RST_N),
        .PS2_CLK (PS2_CLK),
        .PS2_DATA(PS2_DATA),
        .byte_vld(byte_vld),
        .byte_err(byte_err),
        .byte_dat(byte_dat)
    );

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) dec_state <= BASE;
        else        dec_state <= dec_nxt;
    end

    always_comb begin
        dec_nxt = dec_state;
        if (byte_err) begin
            dec_nxt = BASE;
        end else if (byte_vld) begin
            unique case (dec_state)
                BASE:    dec_nxt = (byte_dat == PFX_EXT) ? EXT :
                                   (byte_dat == PFX_BRK) ? BRK : BASE;
                EXT:     dec_nxt = (byte_dat == PFX_BRK) ? EXT_BRK : BASE;
                default: dec_nxt = BASE;
            endcase
        end
    end

    always_comb begin
        evt.ext  = (dec_state == EXT) || (dec_state == EXT_BRK);
        evt.brk  = (dec_state == BRK) || (dec_state == EXT_BRK);
        evt.code = byte_dat;
        evt_vld  = 1'b0;
        if (byte_vld) begin
            unique case (dec_state)
                BASE:    evt_vld = (byte_dat != PFX_EXT) && (byte_dat != PFX_BRK);
                EXT:     evt_vld = (byte_dat != PFX_BRK);
                default: evt_vld = 1'b1;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       rec_vld, rec_hit;
    logic [8:0] rec_key;

    // A held key repeats its make code; only the first make after a release passes.
    assign rec_hit = rec_vld && (rec_key == {evt.ext, evt.code});
    assign emit    = evt_vld && !(rec_hit && !evt.brk);

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            rec_vld <= 1'b0;
            rec_key <= 9'd0;
        end else if (evt_vld) begin
            if (!evt.brk) begin
                rec_vld <= 1'b1;
                rec_key <= {evt.ext, evt.code};
            end else if (rec_hit) begin
                rec_vld <= 1'b0;
            end
        end
    end
`else
    assign emit = evt_vld;
`endif

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            LED       <= 7'd0;
        end else begin
            key_valid <= emit;
            frame_err <= byte_err;
            if (emit) begin
                key_code  <= evt.code;
                key_ext   <= evt.ext;
                key_break <= evt.brk;
                if (evt.ext && !evt.brk) begin
                    if (evt.code == KEY_UP && LED != 7'd127)
                        LED <= LED + 7'd1;
                    else if (evt.code == KEY_DOWN && LED != 7'd0)
                        LED <= LED - 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed frames plus random byte streams against a scoreboard model of the key protocol.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

    localparam int W  = 300;
    localparam int SY = 2;
    localparam int H  = 4;

    logic       CLK50 = 1'b0;
    logic       RST_N, PS2_CLK, PS2_DATA;
    logic       key_valid, key_ext, key_break, frame_err;
    logic [7:0] key_code;
    logic [6:0] LED;

    ps2_key_ctrl #(.WDOG_CYCLES(W), .SYNC_STAGES(SY)) dut (
        .CLK50(CLK50), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .frame_err(frame_err), .LED(LED)
    );

    always #10 CLK50 = ~CLK50;

    int cyc = 0;
    always @(posedge CLK50) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         err;
        logic [7:0] b;
    } rx_ev_t;
    rx_ev_t evq[$];

    int         n_chk = 0, n_fail = 0, kv_seen = 0, fe_seen = 0;
    bit         m_ext, m_brk, m_e, m_k, exp_kv, exp_fe, f_vld;
    logic [8:0] f_key;
    logic [7:0] m_code;
    int         m_led;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        evq.delete();
        m_ext = 0; m_brk = 0; m_e = 0; m_k = 0; m_code = 8'h00; m_led = 0;
        f_vld = 0; f_key = 9'd0;
    endtask

    task automatic apply_ev(input rx_ev_t e);
        bit x, k, show;
        if (e.err) begin
            exp_fe = 1; m_ext = 0; m_brk = 0;
        end else if (!m_ext && !m_brk && e.b == PFX_EXT) begin
            m_ext = 1;
        end else if (!m_brk && e.b == PFX_BRK) begin
            m_brk = 1;
        end else begin
            x = m_ext; k = m_brk; m_ext = 0; m_brk = 0; show = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!k && f_vld && f_key == {x, e.b}) show = 0;
            if (!k) begin f_vld = 1; f_key = {x, e.b}; end
            else if (f_vld && f_key == {x, e.b}) f_vld = 0;
`endif
            if (show) begin
                exp_kv = 1; m_code = e.b; m_e = x; m_k = k;
                if (x && !k && e.b == KEY_UP)   m_led = (m_led < 127) ? m_led + 1 : 127;
                if (x && !k && e.b == KEY_DOWN) m_led = (m_led > 0) ? m_led - 1 : 0;
            end
        end
    endtask

    always @(negedge CLK50) begin
        exp_kv = 0; exp_fe = 0;
        while (evq.size() > 0 && evq[0].at == cyc) apply_ev(evq.pop_front());
        if (key_valid === 1'b1) kv_seen++;
        if (frame_err === 1'b1) fe_seen++;
        chk("key_valid", key_valid, exp_kv);
        chk("frame_err", frame_err, exp_fe);
        chk("key_code", key_code, m_code);
        chk("key_ext", key_ext, m_e);
        chk("key_break", key_break, m_k);
        chk("led", LED, m_led);
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            PS2_DATA = bits[i];
            repeat (H) @(negedge CLK50);
            PS2_CLK = 1'b0;
            if (i == 10) evq.push_back(rx_ev_t'{cyc + SY + 1, bad_par | bad_stop, b});
            repeat (H) @(negedge CLK50);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    // Start bit plus nbits data bits, then the clock stays high until the watchdog fires.
    task automatic send_partial(input int nbits);
        PS2_DATA = 1'b0;
        repeat (H) @(negedge CLK50);
        PS2_CLK = 1'b0;
        evq.push_back(rx_ev_t'{cyc + SY + 1 + W, 1'b1, 8'h00});
        repeat (H) @(negedge CLK50);
        PS2_CLK = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = 1'($urandom_range(0, 1));
            repeat (H) @(negedge CLK50);
            PS2_CLK = 1'b0;
            repeat (H) @(negedge CLK50);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK50);
        #1;
        RST_N = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1;
        model_reset();
        repeat (4) @(negedge CLK50);
        chk("rst_led", LED, 7'd0);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_valid", key_valid, 1'b0);
        #1 RST_N = 1'b1;
        repeat (8) @(negedge CLK50);
    endtask

    initial begin
        int kv0, fe0;
        logic [7:0] b;
        bit bp, bs;
        model_reset();
        RST_N = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1;
        repeat (4) @(negedge CLK50);
        chk("rst0_led", LED, 7'd0);
        chk("rst0_frame_err", frame_err, 1'b0);
        #1 RST_N = 1'b1;
        repeat (8) @(negedge CLK50);

        kv0 = kv_seen;
        send_frame(8'h1C);
        repeat (4) @(negedge CLK50);
        chk("single_1c_count", kv_seen - kv0, 1);
        chk("single_1c_code", key_code, 8'h1C);
        chk("single_1c_ext", key_ext, 1'b0);
        chk("single_1c_brk", key_break, 1'b0);

`ifndef PS2_TYPEMATIC_FILTER_EN
        repeat (3) begin send_frame(PFX_EXT); send_frame(KEY_UP); end
        repeat (4) @(negedge CLK50);
        chk("up_x3_led", LED, 7'd3);
        send_frame(PFX_EXT); send_frame(PFX_BRK); send_frame(KEY_UP);
        repeat (4) @(negedge CLK50);
        chk("up_break_ext", key_ext, 1'b1);
        chk("up_break_brk", key_break, 1'b1);
        chk("up_break_led", LED, 7'd3);
        do_reset();
        send_frame(PFX_EXT); send_frame(KEY_DOWN);
        repeat (4) @(negedge CLK50);
        chk("down_floor_led", LED, 7'd0);
        repeat (128) begin send_frame(PFX_EXT); send_frame(KEY_UP); end
        repeat (4) @(negedge CLK50);
        chk("up_ceiling_led", LED, 7'd127);
`else
        kv0 = kv_seen;
        repeat (4) begin send_frame(PFX_EXT); send_frame(KEY_UP); end
        repeat (4) @(negedge CLK50);
        chk("filter_count", kv_seen - kv0, 1);
        chk("filter_led1", LED, 7'd1);
        send_frame(PFX_EXT); send_frame(PFX_BRK); send_frame(KEY_UP);
        send_frame(PFX_EXT); send_frame(KEY_UP);
        repeat (4) @(negedge CLK50);
        chk("filter_led2", LED, 7'd2);
`endif

        kv0 = kv_seen; fe0 = fe_seen;
        send_frame(8'h1C, 1'b1);
        repeat (4) @(negedge CLK50);
        chk("bad_par_err", fe_seen - fe0, 1);
        chk("bad_par_nokey", kv_seen - kv0, 0);
        send_frame(8'h1C);
        repeat (4) @(negedge CLK50);
        chk("after_par_key", kv_seen - kv0, 1);

        fe0 = fe_seen;
        send_partial(3);
        repeat (W + 40) @(negedge CLK50);
        chk("wdog_err", fe_seen - fe0, 1);
        kv0 = kv_seen;
        send_frame(8'h29);
        repeat (4) @(negedge CLK50);
        chk("after_wdog_key", kv_seen - kv0, 1);
        chk("after_wdog_code", key_code, 8'h29);

        send_partial(4);
        do_reset();
        kv0 = kv_seen; fe0 = fe_seen;
        repeat (W + 40) @(negedge CLK50);
        chk("midframe_rst_quiet", (kv_seen - kv0) + (fe_seen - fe0), 0);
        send_frame(8'h1C);
        repeat (4) @(negedge CLK50);
        chk("midframe_rst_key", kv_seen - kv0, 1);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = PFX_EXT;
                2, 3:    b = PFX_BRK;
                4:       b = KEY_UP;
                5:       b = KEY_DOWN;
                6:       b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 19) == 0);
            bs = ($urandom_range(0, 29) == 0);
            send_frame(b, bp, bs);
            repeat ($urandom_range(0, 20)) @(negedge CLK50);
        end
        repeat (20) @(negedge CLK50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
